// File: rtl/tl_pkg.sv
// Shared lamp codes, phase encoding and per-lamp decode for the intersection arbiter.
package tl_pkg;

    localparam int unsigned LAMP_W = 3;

    localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_RED = 3'b001;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } phase_t;

    // Lamp shown by one approach: only the owner ever leaves red.
    function automatic logic [LAMP_W-1:0] lamp_of(phase_t phase, logic is_owner);
        logic [LAMP_W-1:0] lamp;
        lamp = LAMP_RED;
        if (is_owner && phase == GREEN) begin
            lamp = LAMP_GRN;
        end else if (is_owner && phase == YELLOW) begin
            lamp = LAMP_YEL;
        end
        return lamp;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Combinational round-robin picker: first requesting approach after owner, with wrap.
// When no other approach requests, next_id holds the current owner and found is low.
module rr_next_sel
    import tl_pkg::*;
#(
    parameter int unsigned N_APP = 4,
    localparam int unsigned ID_W = $clog2(N_APP)
) (
    input  logic [N_APP-1:0] req,
    input  logic [ID_W-1:0]  owner,
    output logic [ID_W-1:0]  next_id,
    output logic             found
);

    int unsigned idx;

    // Scan owner+1, owner+2, ... modulo N_APP; the owner itself is never picked.
    always_comb begin
        next_id = owner;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k < N_APP; k++) begin
            idx = (32'(owner) + k) % N_APP;
            if (!found && req[ID_W'(idx)]) begin
                found   = 1'b1;
                next_id = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/intersection_phase_arbiter.sv
// Round-robin right-of-way arbiter for one intersection.
// Each handover runs green -> yellow -> all-red clearance -> next green.
// Optional feature macro: EMERGENCY_PREEMPT_EN adds emg_req/emg_id preemption.
module intersection_phase_arbiter
    import tl_pkg::*;
#(
    parameter int unsigned N_APP     = 4,
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 8,
    parameter int unsigned YEL_CYC   = 3,
    parameter int unsigned CLR_CYC   = 2,
    parameter int unsigned CNT_W     = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_APP-1:0]            req,
    output logic [LAMP_W*N_APP-1:0]     light,
    output logic [$clog2(N_APP)-1:0]    grant_id,
    output logic                        in_clear
`ifdef EMERGENCY_PREEMPT_EN
    ,
    input  logic                        emg_req,
    input  logic [$clog2(N_APP)-1:0]    emg_id
`endif
);

    localparam int unsigned ID_W = $clog2(N_APP);

    phase_t            state;
    logic [ID_W-1:0]   owner;
    logic [CNT_W-1:0]  timer;

    logic [N_APP-1:0]  owner_oh;
    logic              others;
    logic              own_req;
    logic              green_max_hit;
    logic              leave_green;
    logic [ID_W-1:0]   pick;
    logic              pick_found;
    logic [ID_W-1:0]   next_owner;

    // Full lamp vector for a given phase and owner.
    function automatic logic [LAMP_W*N_APP-1:0] decode_lamps(phase_t phase, logic [ID_W-1:0] own);
        logic [LAMP_W*N_APP-1:0] lamps;
        lamps = '0;
        for (int unsigned i = 0; i < N_APP; i++) begin
            lamps[LAMP_W*i +: LAMP_W] = lamp_of(phase, own == ID_W'(i));
        end
        return lamps;
    endfunction

    rr_next_sel #(
        .N_APP (N_APP)
    ) u_rr_next_sel (
        .req     (req),
        .owner   (owner),
        .next_id (pick),
        .found   (pick_found)
    );

    assign grant_id = owner;

    // Competing demand: the owner's own sensor never counts as a handover request.
    always_comb begin
        owner_oh      = N_APP'(1) << owner;
        others        = |(req & ~owner_oh);
        own_req       = |(req & owner_oh);
        green_max_hit = (timer >= CNT_W'(GREEN_MAX - 1));
    end

    // Decide whether the current green ends at this edge.
    always_comb begin
        leave_green = others &&
                      (((timer >= CNT_W'(GREEN_MIN - 1)) && !own_req) || green_max_hit);
`ifdef EMERGENCY_PREEMPT_EN
        if (emg_req) begin
            leave_green = (owner != emg_id);
        end
`endif
    end

    // Owner for the next green, fixed on the last all-red cycle.
    always_comb begin
        next_owner = pick_found ? pick : owner;
`ifdef EMERGENCY_PREEMPT_EN
        if (emg_req) begin
            next_owner = emg_id;
        end
`endif
    end

    // Phase sequencer with inline phase timer and registered lamp outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= GREEN;
            owner    <= '0;
            timer    <= '0;
            light    <= decode_lamps(GREEN, '0);
            in_clear <= 1'b0;
        end else begin
            case (state)
                GREEN: begin
                    if (leave_green) begin
                        state <= YELLOW;
                        timer <= '0;
                        light <= decode_lamps(YELLOW, owner);
                    end else if (!green_max_hit) begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                YELLOW: begin
                    if (timer == CNT_W'(YEL_CYC - 1)) begin
                        state    <= ALLRED;
                        timer    <= '0;
                        light    <= decode_lamps(ALLRED, owner);
                        in_clear <= 1'b1;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                ALLRED: begin
                    if (timer == CNT_W'(CLR_CYC - 1)) begin
                        state    <= GREEN;
                        timer    <= '0;
                        owner    <= next_owner;
                        light    <= decode_lamps(GREEN, next_owner);
                        in_clear <= 1'b0;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= GREEN;
                    timer    <= '0;
                    light    <= decode_lamps(GREEN, owner);
                    in_clear <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Self-checking bench for intersection_phase_arbiter (N_APP=4, GREEN 4..8, YEL 3, CLR 2).
module tb_intersection_phase_arbiter;

    localparam int N_APP     = 4;
    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 8;
    localparam int YEL_CYC   = 3;
    localparam int CLR_CYC   = 2;
    localparam int CNT_W     = 5;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = 4'b0000;
    logic [11:0] light;
    logic [1:0]  grant_id;
    logic        in_clear;
`ifdef EMERGENCY_PREEMPT_EN
    logic        emg_req = 1'b0;
    logic [1:0]  emg_id  = 2'd0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    intersection_phase_arbiter #(
        .N_APP     (N_APP),
        .GREEN_MIN (GREEN_MIN),
        .GREEN_MAX (GREEN_MAX),
        .YEL_CYC   (YEL_CYC),
        .CLR_CYC   (CLR_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .light    (light),
        .grant_id (grant_id),
        .in_clear (in_clear)
`ifdef EMERGENCY_PREEMPT_EN
        ,
        .emg_req  (emg_req),
        .emg_id   (emg_id)
`endif
    );

    // Reference model: owner, cycles already spent green, cycles left in the handover
    // (yellow + clearance counted down together; 0 means green).
    int m_owner = 0;
    int m_age   = 0;
    int m_left  = 0;

    function automatic bit green_leaves(int own, int served, logic [3:0] r);
        logic [3:0] oth;
        oth = r;
        oth[2'(own)] = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
        if (emg_req) return (own != int'(emg_id));
`endif
        if (oth == 4'b0000) return 1'b0;
        return (served >= GREEN_MAX) || (served >= GREEN_MIN && !r[2'(own)]);
    endfunction

    function automatic int next_owner_of(int own, logic [3:0] r);
`ifdef EMERGENCY_PREEMPT_EN
        if (emg_req) return int'(emg_id);
`endif
        for (int k = 1; k < N_APP; k++) begin
            if (r[2'((own + k) % N_APP)]) return (own + k) % N_APP;
        end
        return own;
    endfunction

    function automatic logic [11:0] model_light(int own, int left);
        logic [11:0] v;
        logic [2:0]  lamp;
        v    = {4{3'b001}};
        lamp = (left == 0) ? 3'b100 : ((left > CLR_CYC) ? 3'b010 : 3'b001);
        case (own)
            0:       v[2:0]  = lamp;
            1:       v[5:3]  = lamp;
            2:       v[8:6]  = lamp;
            default: v[11:9] = lamp;
        endcase
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner <= 0;
            m_age   <= 0;
            m_left  <= 0;
        end else if (m_left == 0) begin
            if (green_leaves(m_owner, m_age + 1, req)) begin
                m_left <= YEL_CYC + CLR_CYC;
                m_age  <= 0;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (m_left == 1) begin
            m_owner <= next_owner_of(m_owner, req);
            m_left  <= 0;
            m_age   <= 0;
        end else begin
            m_left <= m_left - 1;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b0000;
`ifdef EMERGENCY_PREEMPT_EN
        emg_req = 1'b0;
        emg_id  = 2'd0;
`endif
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        req = 4'b1110;
        #1;
        checks++;
        if (light !== 12'b001_001_001_100 || grant_id !== 2'd0 || in_clear !== 1'b0) begin
            failures++;
            $display("FAIL reset_state light=%b grant=%0d clr=%b exp light=001001001100 grant=0 clr=0",
                     light, grant_id, in_clear);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (light !== 12'b001_001_001_100 || grant_id !== 2'd0 || in_clear !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold light=%b grant=%0d clr=%b exp light=001001001100 grant=0 clr=0",
                     light, grant_id, in_clear);
        end
        req   = 4'b0000;
        reset = 1'b1;
    endtask

    task automatic test_handover();
        logic [11:0] exp_l;
        logic [1:0]  exp_g;
        logic        exp_c;
        apply_reset();
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            exp_g = 2'd0;
            exp_c = 1'b0;
            if (i < 4)       exp_l = 12'b001_001_001_100;
            else if (i < 7)  exp_l = 12'b001_001_001_010;
            else if (i < 9) begin exp_l = 12'b001_001_001_001; exp_c = 1'b1; end
            else begin       exp_l = 12'b001_100_001_001; exp_g = 2'd2; end
            checks++;
            if (light !== exp_l || grant_id !== exp_g || in_clear !== exp_c) begin
                failures++;
                $display("FAIL handover cyc=%0d light=%b grant=%0d clr=%b exp %b %0d %b",
                         i, light, grant_id, in_clear, exp_l, exp_g, exp_c);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_yellow();
        apply_reset();
        req = 4'b0010;
        repeat (4) @(negedge clk);
        checks++;
        if (light !== 12'b001_001_001_010) begin
            failures++;
            $display("FAIL mid_yellow_pre light=%b exp=001001001010", light);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (light !== 12'b001_001_001_100 || grant_id !== 2'd0 || in_clear !== 1'b0) begin
            failures++;
            $display("FAIL mid_yellow_abort light=%b grant=%0d clr=%b exp light=001001001100 grant=0 clr=0",
                     light, grant_id, in_clear);
        end
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (light !== 12'b001_001_001_100 || grant_id !== 2'd0 || in_clear !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold cyc=%0d light=%b grant=%0d clr=%b", i, light, grant_id, in_clear);
            end
        end
    endtask

    task automatic test_round_robin();
        int          exp_seq [4] = '{1, 3, 0, 1};
        logic [1:0]  prev;
        int          n;
        apply_reset();
        req = 4'b0010;
        for (int s = 0; s < 4; s++) begin
            prev = grant_id;
            n    = 0;
            while (grant_id == prev && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (grant_id !== 2'(exp_seq[s])) begin
                failures++;
                $display("FAIL round_robin step=%0d grant=%0d exp=%0d waited=%0d", s, grant_id, exp_seq[s], n);
            end
            req = 4'b1011;
        end
    endtask

    task automatic test_green_max();
        int count;
        int n;
        apply_reset();
        req   = 4'b0011;
        count = 0;
        n     = 0;
        while (light[2:0] == 3'b100 && n < 40) begin
            count++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (count != GREEN_MAX) begin
            failures++;
            $display("FAIL green_max green_cycles=%0d exp=%0d", count, GREEN_MAX);
        end
        checks++;
        if (light !== 12'b001_001_001_010) begin
            failures++;
            $display("FAIL green_max_yellow light=%b exp=001001001010", light);
        end
        repeat (YEL_CYC + CLR_CYC - 1 + 1) @(negedge clk);
        checks++;
        if (grant_id !== 2'd1 || light !== 12'b001_001_100_001) begin
            failures++;
            $display("FAIL green_max_next grant=%0d light=%b exp grant=1 light=001001100001", grant_id, light);
        end
    endtask

    task automatic test_withdraw();
        logic [11:0] exp_l;
        logic        exp_c;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            exp_c = 1'b0;
            if (i < 4)      exp_l = 12'b001_001_001_100;
            else if (i < 7) exp_l = 12'b001_001_001_010;
            else if (i < 9) begin exp_l = 12'b001_001_001_001; exp_c = 1'b1; end
            else            exp_l = 12'b001_001_001_100;
            checks++;
            if (light !== exp_l || grant_id !== 2'd0 || in_clear !== exp_c) begin
                failures++;
                $display("FAIL withdraw cyc=%0d light=%b grant=%0d clr=%b exp %b 0 %b",
                         i, light, grant_id, in_clear, exp_l, exp_c);
            end
            if (i == 3) req = 4'b0010;
            if (i == 4) req = 4'b0000;
            @(negedge clk);
        end
    endtask

`ifdef EMERGENCY_PREEMPT_EN
    task automatic test_emergency();
        logic [11:0] exp_l;
        logic [1:0]  exp_g;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            exp_g = 2'd0;
            if (i < 2)      exp_l = 12'b001_001_001_100;
            else if (i < 5) exp_l = 12'b001_001_001_010;
            else if (i < 7) exp_l = 12'b001_001_001_001;
            else begin      exp_l = 12'b100_001_001_001; exp_g = 2'd3; end
            checks++;
            if (light !== exp_l || grant_id !== exp_g) begin
                failures++;
                $display("FAIL emergency cyc=%0d light=%b grant=%0d exp %b %0d", i, light, grant_id, exp_l, exp_g);
            end
            if (i == 1) begin
                emg_req = 1'b1;
                emg_id  = 2'd3;
            end
            if (i == 7) req = 4'b0111;
            @(negedge clk);
        end
        emg_req = 1'b0;
        req     = 4'b0000;
    endtask
`endif

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            checks++;
            if (light !== model_light(m_owner, m_left) || grant_id !== 2'(m_owner) ||
                in_clear !== (m_left != 0 && m_left <= CLR_CYC)) begin
                failures++;
                $display("FAIL random cyc=%0d light=%b grant=%0d clr=%b exp light=%b grant=%0d",
                         i, light, grant_id, in_clear, model_light(m_owner, m_left), m_owner);
            end
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
`ifdef EMERGENCY_PREEMPT_EN
            if ($urandom_range(0, 29) == 0) begin
                emg_req = ~emg_req;
                emg_id  = 2'($urandom_range(0, 3));
            end
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_handover();
        test_reset_mid_yellow();
        test_round_robin();
        test_green_max();
        test_withdraw();
`ifdef EMERGENCY_PREEMPT_EN
        test_emergency();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
